hs32_fetch: RTL and testbench

Instruction fetch stage of the HS32 core, directly upstream of `hs32_decode`. It owns the program counter, issues word reads on the memory request port, buffers returned instruction words and hands them to decode over the `reqd`/`rdyd` handshake. A flush from `hs32_exec` (`flush`/`newpc`) redirects the PC, drops buffered words and discards any in-flight response.

---
 rtl/hs32_fetch_pkg.sv | 19 +
 rtl/hs32_fetch_fifo.sv | 68 ++++++
 rtl/hs32_fetch.sv | 106 ++++++++++
 tb/tb_hs32_fetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_fetch_pkg.sv
// Shared definitions for the HS32 fetch stage: FSM states, word size, reset vector and
// the buffered {pc, inst} entry.
package hs32_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

  localparam int unsigned HS32_WORD_BYTES = 4;
  localparam logic [31:0] HS32_RESET_VEC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/hs32_fetch_fifo.sv
// Shift-style instruction buffer: entry 0 is always the head, so the head output holds its last
// value once the buffer drains. Push and pop may happen together at any occupancy.
module hs32_fetch_fifo
  import hs32_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_clear,
  input  fetch_entry_t                   i_data,
  output fetch_entry_t                   o_head,
  output logic [$clog2(Depth+1)-1:0]     o_count,
  output logic                           o_empty,
  output logic                           o_full
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  fetch_entry_t    r_mem [Depth];
  fetch_entry_t    w_mem [Depth];
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count;
  logic            w_pop;
  logic            w_push;

  always_comb begin
    int unsigned cnt;
    int unsigned wr_idx;
    cnt     = 32'(r_count);
    w_pop   = i_pop && (cnt != 0);
    w_push  = i_push && (w_pop || (cnt != Depth));
    wr_idx  = cnt - 32'(w_pop);
    w_mem   = r_mem;
    w_count = r_count;
    if (i_clear) begin
      w_count = '0;
    end else begin
      // On the last pop the head slot is left untouched so the outputs hold their value.
      for (int unsigned i = 0; i < Depth - 1; i++) begin
        if (w_pop && (i + 1 < cnt)) w_mem[IdxW'(i)] = r_mem[IdxW'(i + 1)];
      end
      for (int unsigned i = 0; i < Depth; i++) begin
        if (w_push && (i == wr_idx)) w_mem[IdxW'(i)] = i_data;
      end
      w_count = CntW'(cnt + 32'(w_push) - 32'(w_pop));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_mem   <= '{default: '0};
    end else begin
      r_count <= w_count;
      r_mem   <= w_mem;
    end
  end

  assign o_head  = r_mem[0];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (32'(r_count) == Depth);

endmodule

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: owns the PC, issues word reads and buffers words for decode.
// Define HS32_FETCH_PREFETCH_EN for a two-entry buffer with fetch-ahead (one word per cycle).
module hs32_fetch
  import hs32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = HS32_RESET_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] newpc,
  input  logic        reqd,
  output logic        rdyd,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic [31:0] addr,
  input  logic [31:0] dtr,
  output logic        reqm,
  input  logic        rdym
);

`ifdef HS32_FETCH_PREFETCH_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [31:0]     r_pc;
  logic [31:0]     w_pc_next;
  logic [31:0]     r_addr;
  logic            w_push;
  logic            w_pop;
  logic            w_rdyd;
  logic            w_empty;
  logic            w_full;
  logic            w_room;
  logic [CntW-1:0] w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_entry;

  assign w_rdyd  = !w_empty && !flush;
  assign w_pop   = reqd && w_rdyd;
  assign w_push  = (r_state == StReq) && rdym && !flush;
  // Room for another read once this cycle's push and pop have settled.
  assign w_room  = (32'(w_count) + 32'(w_push) - 32'(w_pop)) < DEPTH;
  assign w_entry = '{pc: r_addr, inst: dtr};

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (flush) begin
      w_pc_next = newpc & ~32'h3;
      unique case (r_state)
        StIdle:           w_state_next = StReq;
        StReq, StDiscard: w_state_next = rdym ? StReq : StDiscard;
        default:          w_state_next = StIdle;
      endcase
    end else begin
      if (w_push) w_pc_next = r_pc + 32'(HS32_WORD_BYTES);
      unique case (r_state)
        StIdle:    if (!w_full || w_pop) w_state_next = StReq;
        StReq:     if (rdym) w_state_next = w_room ? StReq : StIdle;
        StDiscard: if (rdym) w_state_next = StReq;
        default:   w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_pc    <= RESET_VEC;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      // Address only moves when a new read starts; DISCARD keeps the stale one.
      if (w_state_next == StReq) r_addr <= w_pc_next;
    end
  end

  hs32_fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign rdyd  = w_rdyd;
  assign instd = w_head.inst;
  assign pcd   = w_head.pc;
  assign addr  = r_addr;
  assign reqm  = (r_state != StIdle);

endmodule

// File: tb/tb_hs32_fetch.sv
// Scoreboard bench for hs32_fetch: directed scenarios push expected {pc, inst} pairs, and a
// negedge monitor pops and compares on every decode transfer.
module tb_hs32_fetch;

`ifdef HS32_FETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] newpc = 32'h0;
  logic        reqd = 1'b0;
  logic        rdyd;
  logic [31:0] instd, pcd, addr;
  logic [31:0] dtr = 32'h0;
  logic        reqm;
  logic        rdym = 1'b0;

  logic        rst_rv = 1'b1;
  logic        flush_rv = 1'b0;
  logic [31:0] newpc_rv = 32'h0;
  logic        reqd_rv = 1'b1;
  logic        rdyd_rv, reqm_rv;
  logic [31:0] instd_rv, pcd_rv, addr_rv;
  logic        rdym_rv;
  logic [31:0] dtr_rv;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int xfer_total = 0;
  int xfer_cyc_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_rv_addr_q[$];
  logic [31:0] exp_rv_pc_q[$];

  int          mem_waits = 0;
  int          wcnt = 0;
  logic        stale_en = 1'b0;
  logic [31:0] stale_addr = 32'h0;

  hs32_fetch dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .newpc (newpc),
    .reqd  (reqd),
    .rdyd  (rdyd),
    .instd (instd),
    .pcd   (pcd),
    .addr  (addr),
    .dtr   (dtr),
    .reqm  (reqm),
    .rdym  (rdym)
  );

  hs32_fetch #(
    .RESET_VEC (32'hFFFF_FFF8)
  ) dut_rv (
    .clk   (clk),
    .reset (rst_rv),
    .flush (flush_rv),
    .newpc (newpc_rv),
    .reqd  (reqd_rv),
    .rdyd  (rdyd_rv),
    .instd (instd_rv),
    .pcd   (pcd_rv),
    .addr  (addr_rv),
    .dtr   (dtr_rv),
    .reqm  (reqm_rv),
    .rdym  (rdym_rv)
  );

  // Zero-wait memory for the reset-vector instance.
  assign rdym_rv = reqm_rv;
  assign dtr_rv  = addr_rv ^ 32'hA5A5_0000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_inst_q.push_back(pc ^ 32'hA5A5_0000);
  endtask

  task automatic wait_xfers(input int target, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      if (xfer_total >= target) break;
      @(posedge clk); #1;
    end
    check(name, 32'(xfer_total), 32'(target));
  endtask

  // Leaves reset asserted, returning at posedge+1 so the caller can release it.
  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    reqd  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_reqm", reqm, 0);
    check("rst_rdyd", rdyd, 0);
    check("rst_addr", addr, 0);
    check("rst_instd", instd, 0);
    check("rst_pcd", pcd, 0);
    @(posedge clk); #1;
  endtask

  // Memory model: mem_waits wait states per read, data = addr ^ A5A5_0000.
  initial begin
    forever begin
      @(negedge clk);
      if (reqm && !rdym) wcnt = wcnt + 1;
      else wcnt = 0;
      @(posedge clk); #1;
      rdym = reqm && (wcnt >= mem_waits);
      dtr  = (stale_en && addr == stale_addr) ? 32'hDEAD_BEEF : (addr ^ 32'hA5A5_0000);
    end
  end

  always @(negedge clk) begin
    if (!reset && rdyd && reqd && !flush) begin
      xfer_total++;
      xfer_cyc_q.push_back(cyc);
      if (exp_pc_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_xfer: got pcd %08h, want no transfer", pcd);
      end else begin
        check("xfer_pcd", pcd, exp_pc_q.pop_front());
        check("xfer_instd", instd, exp_inst_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_rv && reqm_rv && rdym_rv && exp_rv_addr_q.size() > 0)
      check("rv_addr", addr_rv, exp_rv_addr_q.pop_front());
    if (!rst_rv && rdyd_rv && exp_rv_pc_q.size() > 0) begin
      check("rv_instd", instd_rv, exp_rv_pc_q[0] ^ 32'hA5A5_0000);
      check("rv_pcd", pcd_rv, exp_rv_pc_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Streaming with zero-wait memory and decode always ready.
    do_reset();
    mem_waits = 0;
    xfer_total = 0;
    xfer_cyc_q.delete();
    for (int k = 0; k < 8; k++) push_exp(32'(4 * k));
    reqd  = 1'b1;
    reset = 1'b0;
    t0    = cyc;
    @(negedge clk);
    check("t1_c1_reqm", reqm, 0);
    @(negedge clk);
    check("t1_c2_reqm", reqm, 1);
    check("t1_c2_addr", addr, 32'h0);
    wait_xfers(8, 60, "t1_xfers");
    reqd = 1'b0;
    if (xfer_cyc_q.size() >= 8) begin
      check("t1_first_rdyd_cyc", 32'(xfer_cyc_q[0] - t0 + 1), 32'd3);
      check("t1_rate", 32'(xfer_cyc_q[7] - xfer_cyc_q[0]), (D == 2) ? 32'd7 : 32'd14);
    end

    // Decode stall: fetching must stop, then resume without loss or duplication.
    xfer_total = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 5) check("t2_reqm_stalled", reqm, 0);
    end
    check("t2_rdyd_stalled", rdyd, 1);
    for (int k = 8; k < 14; k++) push_exp(32'(4 * k));
    @(posedge clk); #1;
    reqd = 1'b1;
    wait_xfers(6, 60, "t2_xfers");
    reqd = 1'b0;

    // Flush during a 3-wait-state read: stale data must be dropped.
    do_reset();
    mem_waits  = 3;
    stale_en   = 1'b1;
    stale_addr = 32'h0;
    xfer_total = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    newpc = 32'h0000_1002;
    @(posedge clk); #1;
    flush = 1'b0;
    newpc = 32'h0;
    @(negedge clk);
    check("t3_discard_reqm", reqm, 1);
    check("t3_discard_addr", addr, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (reqm && addr != 32'h0) break;
      @(negedge clk);
    end
    check("t3_redirect_addr", addr, 32'h0000_1000);
    push_exp(32'h0000_1000);
    push_exp(32'h0000_1004);
    @(posedge clk); #1;
    reqd = 1'b1;
    wait_xfers(2, 60, "t3_xfers");
    reqd = 1'b0;
    stale_en = 1'b0;

    // Flush in the same cycle as a completion.
    do_reset();
    mem_waits = 0;
    xfer_total = 0;
    if (D == 1) push_exp(32'h0);
    push_exp(32'h0000_2000);
    push_exp(32'h0000_2004);
    reqd  = 1'b1;
    reset = 1'b0;
    repeat ((D == 2) ? 2 : 3) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    newpc = 32'h0000_2000;
    @(negedge clk);
    check("t4_rdyd_in_flush", rdyd, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    newpc = 32'h0;
    @(negedge clk);
    check("t4_reqm_after", reqm, 1);
    check("t4_addr_after", addr, 32'h0000_2000);
    wait_xfers((D == 2) ? 2 : 3, 40, "t4_xfers");
    reqd = 1'b0;

    // Reset vector near the top of the address space wraps to zero.
    exp_rv_addr_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    exp_rv_pc_q   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    @(posedge clk); #1;
    rst_rv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_rv_addr_q.size() == 0 && exp_rv_pc_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("t5_rv_done", 32'(exp_rv_addr_q.size() + exp_rv_pc_q.size()), 32'd0);

    // Reset while discarding a stale read.
    do_reset();
    mem_waits = 3;
    xfer_total = 0;
    reset = 1'b0;
    flush = 1'b1;
    newpc = 32'h0000_4000;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t6_req_reqm", reqm, 1);
    check("t6_req_addr", addr, 32'h0000_4000);
    @(posedge clk); #1;
    flush = 1'b1;
    newpc = 32'h0000_3000;
    @(posedge clk); #1;
    flush = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t6_discard_reqm", reqm, 1);
    check("t6_discard_addr", addr, 32'h0000_4000);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rst_reqm", reqm, 0);
    check("t6_rst_rdyd", rdyd, 0);
    check("t6_rst_addr", addr, 32'h0);
    mem_waits = 0;
    push_exp(32'h0);
    push_exp(32'h4);
    @(posedge clk); #1;
    reset = 1'b0;
    reqd  = 1'b1;
    wait_xfers(2, 40, "t6_xfers");
    reqd = 1'b0;
    @(posedge clk); #1;
    check("end_exp_left", 32'(exp_pc_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
